fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID stage.

---
 rtl/fetch_stage_pkg.sv | 32 +++
 rtl/fetch_stage_inst_mem.sv | 23 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   WORD_LEN       default datapath / PC width
//   NOP_INSN       encoding squashed into IF/ID on a flush (all zeros)
//   stage_ctrl_e   per-cycle decision of the fetch stage
//   sat_inc        saturating increment used by the performance counters
//   imem_word      built-in program image used by inst_mem
package fetch_stage_pkg;

  localparam int WORD_LEN = 32;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } stage_ctrl_e;

  // Increment v unless it already equals max; callers pass their all-ones value
  // zero-extended to 32 bits and truncate the result back to counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction

  // Program image: word i is "addi x0, x0, i" (immediate in bits 31:20), which
  // makes every location distinct, never equal to the NOP bubble, and easy to
  // recognise in a trace.
  function automatic logic [31:0] imem_word(input logic [31:0] idx);
    return (idx << 20) | 32'h0000_0013;
  endfunction

endpackage

// File: rtl/fetch_stage_inst_mem.sv
// Instruction memory for the fetch stage.
// Combinational, word-indexed read-only memory of IMEM_DEPTH words. The address
// is already reduced to log2(IMEM_DEPTH) bits by the caller, so indexing wraps
// modulo the depth.
// Ports:
//   addr_i   in   AW        word index
//   rdata_o  out  WORD_LEN  instruction at addr_i
module inst_mem #(
  parameter int WORD_LEN   = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic [AW-1:0]       addr_i,
  output logic [WORD_LEN-1:0] rdata_o
);
  import fetch_stage_pkg::*;

  // Contents are a constant table, so synthesis folds this into a ROM.
  always_comb begin
    rdata_o = WORD_LEN'(imem_word(32'(addr_i)));
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, reads instruction memory, freezes on a hazard, redirects on a
// taken branch resolved in ID (inserting one NOP bubble) and counts stall and
// flush events in saturating counters. All outputs come straight from flops.
// Ports:
//   clk              in   1         rising-edge clock
//   rst              in   1         asynchronous active-high reset
//   hazard_detected  in   1         freeze request from the hazard unit
//   Br_Taken_ID      in   1         branch/jump resolved taken in ID
//   Br_target_ID     in   WORD_LEN  redirect byte address
//   PC_ID            out  WORD_LEN  PC+4 of the instruction in IF/ID
//   inst_ID          out  WORD_LEN  instruction in IF/ID
//   valid_ID         out  1         IF/ID holds a real instruction
//   PC_IF            out  WORD_LEN  current fetch PC
//   stall_cnt        out  CNT_W     hazard-freeze cycles, saturating
//   flush_cnt        out  CNT_W     taken-branch flushes, saturating
module fetch_stage #(
  parameter int              WORD_LEN   = 32,
  parameter int              IMEM_DEPTH = 1024,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter int              CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hazard_detected,
  input  logic                Br_Taken_ID,
  input  logic [WORD_LEN-1:0] Br_target_ID,
  output logic [WORD_LEN-1:0] PC_ID,
  output logic [WORD_LEN-1:0] inst_ID,
  output logic                valid_ID,
  output logic [WORD_LEN-1:0] PC_IF,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  import fetch_stage_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] inst_q, inst_d;
  logic [WORD_LEN-1:0] pc_id_q, pc_id_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  stage_ctrl_e         ctrl;
  logic [WORD_LEN-1:0] pc_plus4;
  logic [WORD_LEN-1:0] br_target;
  logic [WORD_LEN-1:0] imem_rdata;

  inst_mem #(
    .WORD_LEN   (WORD_LEN),
    .IMEM_DEPTH (IMEM_DEPTH),
    .AW         (AW)
  ) u_imem (
    .addr_i  (pc_q[AW+1:2]),
    .rdata_o (imem_rdata)
  );

  // Wraps modulo 2^WORD_LEN by construction.
  assign pc_plus4 = pc_q + WORD_LEN'(4);

  // Instructions are word aligned; the low two target bits carry no meaning.
  assign br_target = Br_target_ID & ~WORD_LEN'(3);

  // Stall wins over a branch: ID is frozen too, so it re-resolves the branch
  // once the hazard clears and the redirect is not lost.
  always_comb begin
    if (hazard_detected) begin
      ctrl = STALL;
    end else if (Br_Taken_ID) begin
      ctrl = FLUSH;
    end else begin
      ctrl = RUN;
    end
  end

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    pc_id_d     = pc_id_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (ctrl)
      STALL: begin
        stall_cnt_d = CNT_W'(sat_inc(32'(stall_cnt_q), CNT_MAX));
      end
      FLUSH: begin
        // The instruction fetched this cycle is on the wrong path: drop it.
        pc_d        = br_target;
        inst_d      = WORD_LEN'(NOP_INSN);
        pc_id_d     = '0;
        valid_d     = 1'b0;
        flush_cnt_d = CNT_W'(sat_inc(32'(flush_cnt_q), CNT_MAX));
      end
      default: begin
        pc_d    = pc_plus4;
        inst_d  = imem_rdata;
        pc_id_d = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inst_q      <= WORD_LEN'(NOP_INSN);
      pc_id_q     <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      pc_id_q     <= pc_id_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_IF     = pc_q;
  assign inst_ID   = inst_q;
  assign PC_ID     = pc_id_q;
  assign valid_ID  = valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        hazard_detected;
  logic        Br_Taken_ID;
  logic [31:0] Br_target_ID;
  logic [31:0] PC_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;
  logic [31:0] PC_IF;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int total;
  int bad;

  // Hand-computed program image entries ("addi x0,x0,i").
  localparam logic [31:0] IMEM0    = 32'h0000_0013;
  localparam logic [31:0] IMEM1    = 32'h0010_0013;
  localparam logic [31:0] IMEM2    = 32'h0020_0013;
  localparam logic [31:0] IMEM3    = 32'h0030_0013;
  localparam logic [31:0] IMEM16   = 32'h0100_0013;
  localparam logic [31:0] IMEM1023 = 32'h3FF0_0013;

  fetch_stage #(
    .WORD_LEN   (32),
    .IMEM_DEPTH (1024),
    .RESET_PC   (32'h0),
    .CNT_W      (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_detected (hazard_detected),
    .Br_Taken_ID     (Br_Taken_ID),
    .Br_target_ID    (Br_target_ID),
    .PC_ID           (PC_ID),
    .inst_ID         (inst_ID),
    .valid_ID        (valid_ID),
    .PC_IF           (PC_IF),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic chk_if_id(input string tag, input logic [31:0] pc_if, input logic [31:0] pc_id,
                           input logic [31:0] inst, input logic vld);
    chk({tag, ".PC_IF"},    PC_IF,          pc_if);
    chk({tag, ".PC_ID"},    PC_ID,          pc_id);
    chk({tag, ".inst_ID"},  inst_ID,        inst);
    chk({tag, ".valid_ID"}, 32'(valid_ID),  32'(vld));
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] stalls, input logic [15:0] flushes);
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(stalls));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(flushes));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst             = 1'b1;
    hazard_detected = 1'b0;
    Br_Taken_ID     = 1'b0;
    Br_target_ID    = 32'h0;

    // Reset held across edges, then released.
    step();
    step();
    chk_if_id("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("rst_hold", 16'h0, 16'h0);
    rst = 1'b0;
    chk("rst_release.PC_IF", PC_IF, 32'h0);

    // Straight-line fetch for three edges.
    step();
    chk_if_id("run1", 32'h4, 32'h4, IMEM0, 1'b1);
    step();
    step();
    chk_if_id("run3", 32'hC, 32'hC, IMEM2, 1'b1);

    // Two-cycle hazard freeze at PC_IF=8.
    do_reset();
    step();
    step();
    chk_if_id("pre_stall", 32'h8, 32'h8, IMEM1, 1'b1);
    hazard_detected = 1'b1;
    step();
    chk_if_id("stall1", 32'h8, 32'h8, IMEM1, 1'b1);
    chk_cnt("stall1", 16'd1, 16'd0);
    step();
    chk_if_id("stall2", 32'h8, 32'h8, IMEM1, 1'b1);
    chk_cnt("stall2", 16'd2, 16'd0);
    hazard_detected = 1'b0;
    step();
    chk_if_id("resume", 32'hC, 32'hC, IMEM2, 1'b1);
    step();
    chk_if_id("pc16", 32'h10, 32'h10, IMEM3, 1'b1);

    // Taken branch at PC_IF=16; target low bits must be dropped.
    Br_Taken_ID  = 1'b1;
    Br_target_ID = 32'h43;
    step();
    chk_if_id("flush", 32'h40, 32'h0, 32'h0, 1'b0);
    chk_cnt("flush", 16'd2, 16'd1);
    Br_Taken_ID = 1'b0;
    step();
    chk_if_id("target", 32'h44, 32'h44, IMEM16, 1'b1);

    // Hazard and branch together: hazard wins.
    hazard_detected = 1'b1;
    Br_Taken_ID     = 1'b1;
    Br_target_ID    = 32'h100;
    step();
    chk_if_id("haz_br", 32'h44, 32'h44, IMEM16, 1'b1);
    chk_cnt("haz_br", 16'd3, 16'd1);

    // PC wrap at the top of the address space.
    hazard_detected = 1'b0;
    Br_target_ID    = 32'hFFFF_FFFC;
    step();
    chk_if_id("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    chk_cnt("to_top", 16'd3, 16'd2);
    Br_Taken_ID = 1'b0;
    step();
    chk_if_id("wrap", 32'h0, 32'h0, IMEM1023, 1'b1);
    step();
    chk_if_id("after_wrap", 32'h4, 32'h4, IMEM0, 1'b1);

    // Asynchronous reset pulse between edges.
    #2;
    rst = 1'b1;
    #1;
    chk_if_id("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    chk_cnt("async_rst", 16'd0, 16'd0);
    #1;
    rst = 1'b0;
    step();
    chk_if_id("post_async", 32'h4, 32'h4, IMEM0, 1'b1);

    // Drive stall_cnt to all-ones, then one more stall must not wrap it.
    hazard_detected = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    step();
    chk("sat_hold.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    chk_if_id("sat_hold", 32'h4, 32'h4, IMEM0, 1'b1);
    hazard_detected = 1'b0;
    step();
    chk_if_id("sat_resume", 32'h8, 32'h8, IMEM1, 1'b1);
    chk_cnt("sat_resume", 16'hFFFF, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
